// File: rtl/tick_period_meter_pkg.sv
// Shared definitions for the tick period meter.
// Holds the FSM state encoding, the default counter width and the width of
// the rising-edge counter. Imported by the interface and by every module of
// the meter.
package tick_period_meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_STALLED = 2'd2
    } meter_state_t;

    localparam int DEFAULT_CNT_W = 32;
    localparam int TICK_COUNT_W  = 16;

endpackage

// File: rtl/tick_period_meter_if.sv
// Signal bundle between the tick period meter and its user.
//   tick_in      strobe whose rising edges are measured
//   clear        synchronous statistics clear
//   period       last measured period in clk_in cycles
//   period_valid one-cycle pulse when period/min/max/avg update
//   period_min   smallest period since reset/clear
//   period_max   largest period since reset/clear
//   avg_period   exponential moving average of the periods
//   tick_count   rising edges seen since reset/clear (wraps)
//   stalled      no rising edge for the timeout interval
// master: drives tick_in/clear and observes the results.
// slave:  the meter itself.
interface tick_period_meter_if
    import tick_period_meter_pkg::*;
#(
    parameter int CNT_W = DEFAULT_CNT_W
);
    logic                    tick_in;
    logic                    clear;
    logic [CNT_W-1:0]        period;
    logic                    period_valid;
    logic [CNT_W-1:0]        period_min;
    logic [CNT_W-1:0]        period_max;
    logic [CNT_W-1:0]        avg_period;
    logic [TICK_COUNT_W-1:0] tick_count;
    logic                    stalled;

    modport master (
        output tick_in,
        output clear,
        input  period,
        input  period_valid,
        input  period_min,
        input  period_max,
        input  avg_period,
        input  tick_count,
        input  stalled
    );

    modport slave (
        input  tick_in,
        input  clear,
        output period,
        output period_valid,
        output period_min,
        output period_max,
        output avg_period,
        output tick_count,
        output stalled
    );

endinterface

// File: rtl/tick_period_meter_rise_detect.sv
// Registered rising-edge detector.
//   clk_in  in  system clock
//   reset   in  synchronous, active-high; clears the delayed copy
//   d       in  level input in the clk_in domain
//   rise    out high for the cycle in which d is high and was low last cycle
// A level held high for many cycles produces a single rise.
module rise_detect (
    input  logic clk_in,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic d_dly;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            d_dly <= 1'b0;
        end else begin
            d_dly <= d;
        end
    end

    assign rise = d & ~d_dly;

endmodule

// File: rtl/tick_period_meter.sv
// Tick period meter: measures the spacing of the CPU step strobe in clk_in
// cycles and keeps last period, min, max, moving average, an edge count and
// a stall indication.
//   clk_in  in  system clock
//   reset   in  synchronous, active-high
//   bus     tick_period_meter_if.slave (tick_in, clear in; statistics out)
// Parameters:
//   CNT_W     width of the period counter and of all period outputs
//   TIMEOUT   cycles without a rising edge before stalled is raised
//   AVG_SHIFT moving-average weight is 1/2^AVG_SHIFT
module tick_period_meter
    import tick_period_meter_pkg::*;
#(
    parameter int          CNT_W     = DEFAULT_CNT_W,
    parameter int unsigned TIMEOUT   = 100000000,
    parameter int          AVG_SHIFT = 3
) (
    input  logic                 clk_in,
    input  logic                 reset,
    tick_period_meter_if.slave   bus
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

    // One EMA step: avg + ((sample - avg) >>> AVG_SHIFT). The difference can
    // be negative, so it is formed signed one bit wider than the operands;
    // the arithmetic shift rounds toward minus infinity.
    function automatic logic [CNT_W-1:0] ema_update(
        input logic [CNT_W-1:0] avg,
        input logic [CNT_W-1:0] sample
    );
        logic signed [CNT_W:0] diff;
        logic signed [CNT_W:0] step;
        logic signed [CNT_W:0] sum;
        diff = $signed({1'b0, sample}) - $signed({1'b0, avg});
        step = diff >>> AVG_SHIFT;
        sum  = $signed({1'b0, avg}) + step;
        return sum[CNT_W-1:0];
    endfunction

    // clear behaves exactly like reset, including the edge detector, so a
    // rise coinciding with clear is dropped.
    logic sclr;
    logic rise;

    assign sclr = reset | bus.clear;

    rise_detect u_rise_detect (
        .clk_in (clk_in),
        .reset  (sclr),
        .d      (bus.tick_in),
        .rise   (rise)
    );

    meter_state_t     state;
    meter_state_t     state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             report;

    always_ff @(posedge clk_in) begin
        if (sclr) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // cnt equals the number of cycles since the last rise, so on the next
    // rise it already holds the period. It saturates at TIMEOUT while stalled.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        report    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rise) begin
                    state_nxt = ST_MEASURE;
                    cnt_nxt   = ONE_C;
                end
            end
            ST_MEASURE: begin
                if (rise) begin
                    report  = 1'b1;
                    cnt_nxt = ONE_C;
                end else if (cnt == TIMEOUT_C) begin
                    state_nxt = ST_STALLED;
                end else begin
                    cnt_nxt = cnt + ONE_C;
                end
            end
            ST_STALLED: begin
                if (rise) begin
                    state_nxt = ST_MEASURE;
                    cnt_nxt   = ONE_C;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Statistics stage: registered on the cycle a period completes.
    logic [CNT_W-1:0]        period_p1;
    logic                    vld_p1;
    logic [CNT_W-1:0]        min_p1;
    logic [CNT_W-1:0]        max_p1;
    logic [CNT_W-1:0]        avg_p1;
    logic [TICK_COUNT_W-1:0] tick_count_p1;
    logic                    first;

    always_ff @(posedge clk_in) begin
        if (sclr) begin
            period_p1     <= '0;
            vld_p1        <= 1'b0;
            min_p1        <= '1;
            max_p1        <= '0;
            avg_p1        <= '0;
            tick_count_p1 <= '0;
            first         <= 1'b1;
        end else begin
            vld_p1 <= report;
            if (rise) begin
                tick_count_p1 <= tick_count_p1 + TICK_COUNT_W'(1);
            end
            if (report) begin
                period_p1 <= cnt;
                if (cnt < min_p1) begin
                    min_p1 <= cnt;
                end
                if (cnt > max_p1) begin
                    max_p1 <= cnt;
                end
                if (first) begin
                    avg_p1 <= cnt;
                    first  <= 1'b0;
                end else begin
                    avg_p1 <= ema_update(avg_p1, cnt);
                end
            end
        end
    end

    assign bus.period       = period_p1;
    assign bus.period_valid = vld_p1;
    assign bus.period_min   = min_p1;
    assign bus.period_max   = max_p1;
    assign bus.avg_period   = avg_p1;
    assign bus.tick_count   = tick_count_p1;
    assign bus.stalled      = (state == ST_STALLED);

endmodule
